// File: rtl/tensor_cluster.sv
// Tensor processing cluster: a sequencer fetching 128-bit instructions from a local
// instruction memory and running signed int8 GEMMs on a banked SRAM, int32 results.

module tc_sram_bank #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

module tc_sram #(
    parameter int WIDTH = 256,
    parameter int BANKS = 4,
    parameter int DEPTH = 256
) (
    input  logic                                     clk,
    input  logic                                     en,
    input  logic                                     we,
    input  logic [$clog2(BANKS)+$clog2(DEPTH)-1:0]   addr,
    input  logic [WIDTH-1:0]                         wdata,
    output logic [WIDTH-1:0]                         rdata
);
    localparam int BB = $clog2(BANKS);
    localparam int AW = BB + $clog2(DEPTH);

    logic [BANKS-1:0][WIDTH-1:0] bank_rdata;
    logic [BB-1:0]               bank_sel_q;
    logic [BB-1:0]               bank_sel_d;

    // Low address bits pick the bank so consecutive matrix rows land in different banks.
    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : bank_gen
            tc_sram_bank #(
                .WIDTH(WIDTH),
                .DEPTH(DEPTH)
            ) bank_inst (
                .clk  (clk),
                .en   (en && (addr[BB-1:0] == BB'(gi))),
                .we   (we),
                .addr (addr[AW-1:BB]),
                .wdata(wdata),
                .rdata(bank_rdata[gi])
            );
        end
    endgenerate

    always_comb begin
        bank_sel_d = bank_sel_q;
        if (en && !we) begin
            bank_sel_d = addr[BB-1:0];
        end
    end

    always_ff @(posedge clk) begin
        bank_sel_q <= bank_sel_d;
    end

    assign rdata = bank_rdata[bank_sel_q];
endmodule

module tensor_cluster #(
    parameter int ARRAY_SIZE = 4,
    parameter int SRAM_WIDTH = 256,
    parameter int SRAM_BANKS = 4,
    parameter int SRAM_DEPTH = 256,
    parameter int VPU_LANES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tpc_start,
    input  logic [19:0]             tpc_start_pc,
    output logic                    tpc_busy,
    output logic                    tpc_done,
    output logic                    tpc_error,
    input  logic                    global_sync_in,
    output logic                    sync_request,
    input  logic                    sync_grant,
    input  logic [SRAM_WIDTH-1:0]   noc_rx_data,
    input  logic [19:0]             noc_rx_addr,
    input  logic                    noc_rx_valid,
    input  logic                    noc_rx_is_instr,
    output logic                    noc_rx_ready,
    output logic [SRAM_WIDTH-1:0]   noc_tx_data,
    output logic [19:0]             noc_tx_addr,
    output logic                    noc_tx_valid,
    input  logic                    noc_tx_ready,
    output logic [39:0]             axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [SRAM_WIDTH-1:0]   axi_wdata,
    output logic [SRAM_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic [39:0]             axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [SRAM_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    axi_rready
);
    localparam int AW = $clog2(SRAM_BANKS) + $clog2(SRAM_DEPTH);
    localparam int CW = $clog2(ARRAY_SIZE + 1);
    localparam int RW = ARRAY_SIZE * 8;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_TENSOR = 8'h01;
    localparam logic [7:0] OP_SYNC   = 8'h04;
    localparam logic [7:0] OP_HALT   = 8'hFF;
    localparam logic [7:0] SUB_GEMM  = 8'h01;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, LOAD_W, READ_A, WRITE_C, SYNC_WAIT, HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      pc_q, pc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [CW-1:0]   w_cnt_q, w_cnt_d;
    logic [15:0]     row_q, row_d;
    logic [RW-1:0]   w_reg_q [ARRAY_SIZE];
    logic [RW-1:0]   w_reg_d [ARRAY_SIZE];

    logic [127:0]    instr_mem [256];
    logic [127:0]    instr_rdata_q;
    logic            instr_rd_en;
    logic            instr_wr_en;

    logic            sram_en, sram_we;
    logic [AW-1:0]   sram_addr;
    logic [SRAM_WIDTH-1:0] sram_wdata, sram_rdata, result_word;
    logic            idle_like;

    logic [7:0]  f_op, f_sub;
    logic [15:0] f_dst, f_src_a, f_src_w, f_m, f_n, f_k;

    assign f_op    = instr_rdata_q[127:120];
    assign f_sub   = instr_rdata_q[119:112];
    assign f_dst   = instr_rdata_q[111:96];
    assign f_src_a = instr_rdata_q[95:80];
    assign f_src_w = instr_rdata_q[79:64];
    assign f_m     = instr_rdata_q[63:48];
    assign f_n     = instr_rdata_q[47:32];
    assign f_k     = instr_rdata_q[31:16];

    assign idle_like = (state_q == IDLE) || (state_q == HALTED);

    always_ff @(posedge clk) begin
        if (instr_wr_en) begin
            instr_mem[noc_rx_addr[7:0]] <= noc_rx_data[127:0];
        end
        if (instr_rd_en) begin
            instr_rdata_q <= instr_mem[pc_q];
        end
    end

    tc_sram #(
        .WIDTH(SRAM_WIDTH),
        .BANKS(SRAM_BANKS),
        .DEPTH(SRAM_DEPTH)
    ) sram_inst (
        .clk  (clk),
        .en   (sram_en),
        .we   (sram_we),
        .addr (sram_addr),
        .wdata(sram_wdata),
        .rdata(sram_rdata)
    );

    // One dot product per result lane; activation bytes at k >= K and lanes >= N contribute nothing.
    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : lane_gen
            logic [31:0] acc;
            always_comb begin
                acc = '0;
                for (int k = 0; k < ARRAY_SIZE; k++) begin
                    if (16'(k) < f_k) begin
                        acc = acc + 32'(signed'(sram_rdata[8*k +: 8]))
                                  * 32'(signed'(w_reg_q[gi][8*k +: 8]));
                    end
                end
                if (16'(gi) >= f_n) begin
                    acc = '0;
                end
            end
            assign result_word[32*gi +: 32] = acc;
        end
    endgenerate
    assign result_word[SRAM_WIDTH-1:32*ARRAY_SIZE] = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            w_cnt_q <= '0;
            row_q   <= '0;
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                w_reg_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            w_cnt_q <= w_cnt_d;
            row_q   <= row_d;
            w_reg_q <= w_reg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        w_cnt_d = w_cnt_q;
        row_d   = row_q;
        w_reg_d = w_reg_q;
        case (state_q)
            IDLE, HALTED: begin
                if (tpc_start) begin
                    state_d = FETCH;
                    pc_d    = tpc_start_pc[7:0];
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                case (f_op)
                    OP_NOP: begin
                        pc_d    = pc_q + 8'd1;
                        state_d = FETCH;
                    end
                    OP_SYNC: state_d = SYNC_WAIT;
                    OP_HALT: begin
                        state_d = HALTED;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    OP_TENSOR: begin
                        if (f_sub == SUB_GEMM && f_k <= 16'(ARRAY_SIZE) && f_n <= 16'(ARRAY_SIZE)) begin
                            w_cnt_d = '0;
                            row_d   = '0;
                            state_d = LOAD_W;
                        end else begin
                            state_d = HALTED;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            error_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = HALTED;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                endcase
            end
            LOAD_W: begin
                // Reads are issued back to back; each cycle captures the row requested one cycle earlier.
                if (w_cnt_q != '0) begin
                    w_reg_d[w_cnt_q - CW'(1)] = sram_rdata[RW-1:0];
                end
                if (16'(w_cnt_q) == f_n) begin
                    if (f_m == 16'd0) begin
                        pc_d    = pc_q + 8'd1;
                        state_d = FETCH;
                    end else begin
                        state_d = READ_A;
                    end
                end else begin
                    w_cnt_d = w_cnt_q + CW'(1);
                end
            end
            READ_A: state_d = WRITE_C;
            WRITE_C: begin
                if (row_q + 16'd1 == f_m) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = FETCH;
                end else begin
                    row_d   = row_q + 16'd1;
                    state_d = READ_A;
                end
            end
            SYNC_WAIT: begin
                if (sync_grant) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_request = (state_q == SYNC_WAIT);
        noc_rx_ready = idle_like;
        instr_rd_en  = (state_q == FETCH);
        instr_wr_en  = idle_like && noc_rx_valid && noc_rx_is_instr;
        sram_en      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        case (state_q)
            IDLE, HALTED: begin
                if (noc_rx_valid && !noc_rx_is_instr) begin
                    sram_en    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = noc_rx_addr[AW-1:0];
                    sram_wdata = noc_rx_data;
                end
            end
            LOAD_W: begin
                if (16'(w_cnt_q) != f_n) begin
                    sram_en   = 1'b1;
                    sram_addr = AW'(f_src_w + 16'(w_cnt_q));
                end
            end
            READ_A: begin
                sram_en   = 1'b1;
                sram_addr = AW'(f_src_a + row_q);
            end
            WRITE_C: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = AW'(f_dst + row_q);
                sram_wdata = result_word;
            end
            default: ;
        endcase
    end

    assign tpc_busy  = busy_q;
    assign tpc_done  = done_q;
    assign tpc_error = error_q;

    assign noc_tx_data  = '0;
    assign noc_tx_addr  = '0;
    assign noc_tx_valid = 1'b0;
    assign axi_awaddr   = '0;
    assign axi_awlen    = '0;
    assign axi_awvalid  = 1'b0;
    assign axi_wdata    = '0;
    assign axi_wstrb    = '0;
    assign axi_wlast    = 1'b0;
    assign axi_wvalid   = 1'b0;
    assign axi_bready   = 1'b0;
    assign axi_araddr   = '0;
    assign axi_arlen    = '0;
    assign axi_arvalid  = 1'b0;
    assign axi_rready   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{global_sync_in, noc_tx_ready, tpc_start_pc[19:8], noc_rx_addr[19:AW],
                         axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
                         axi_rdata, axi_rresp, axi_rlast, axi_rvalid, instr_rdata_q[15:0],
                         sram_rdata[SRAM_WIDTH-1:RW], 1'(VPU_LANES)};
endmodule

// File: tb/tb_tensor_cluster.sv
// Randomized bench for tensor_cluster: NoC preload, program runs, and a flat-address
// GEMM reference model compared against the SRAM contents.
`timescale 1ns/1ps
module tb_tensor_cluster;
    localparam int AS = 4;
    localparam int SW = 256;
    localparam int SB = 4;
    localparam int SD = 256;
    localparam logic [127:0] NOP_I  = 128'h0;
    localparam logic [127:0] SYNC_I = {8'h04, 120'h0};
    localparam logic [127:0] HALT_I = {8'hFF, 120'h0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tpc_start = 1'b0;
    logic [19:0]   tpc_start_pc = '0;
    logic          tpc_busy, tpc_done, tpc_error;
    logic          sync_request;
    logic          sync_grant = 1'b0;
    logic [SW-1:0] noc_rx_data = '0;
    logic [19:0]   noc_rx_addr = '0;
    logic          noc_rx_valid = 1'b0;
    logic          noc_rx_is_instr = 1'b0;
    logic          noc_rx_ready;
    logic [SW-1:0] noc_tx_data;
    logic [19:0]   noc_tx_addr;
    logic          noc_tx_valid;
    logic [39:0]   axi_awaddr, axi_araddr;
    logic [7:0]    axi_awlen, axi_arlen;
    logic          axi_awvalid, axi_wlast, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic [SW-1:0] axi_wdata;
    logic [SW/8-1:0] axi_wstrb;

    tensor_cluster dut (
        .clk(clk), .rst(rst), .tpc_start(tpc_start), .tpc_start_pc(tpc_start_pc),
        .tpc_busy(tpc_busy), .tpc_done(tpc_done), .tpc_error(tpc_error),
        .global_sync_in(1'b0), .sync_request(sync_request), .sync_grant(sync_grant),
        .noc_rx_data(noc_rx_data), .noc_rx_addr(noc_rx_addr), .noc_rx_valid(noc_rx_valid),
        .noc_rx_is_instr(noc_rx_is_instr), .noc_rx_ready(noc_rx_ready),
        .noc_tx_data(noc_tx_data), .noc_tx_addr(noc_tx_addr), .noc_tx_valid(noc_tx_valid),
        .noc_tx_ready(1'b0),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(1'b0),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(1'b0), .axi_bresp(2'b00), .axi_bvalid(1'b0), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(1'b0),
        .axi_rdata('0), .axi_rresp(2'b00), .axi_rlast(1'b0), .axi_rvalid(1'b0), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [SW-1:0] mdl [SB*SD];

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] peek(input int addr);
        int w;
        w = addr / SB;
        case (addr % SB)
            0:       peek = dut.sram_inst.bank_gen[0].bank_inst.mem[w];
            1:       peek = dut.sram_inst.bank_gen[1].bank_inst.mem[w];
            2:       peek = dut.sram_inst.bank_gen[2].bank_inst.mem[w];
            default: peek = dut.sram_inst.bank_gen[3].bank_inst.mem[w];
        endcase
    endfunction

    function automatic logic [SW-1:0] rnd_word();
        logic [SW-1:0] v;
        for (int i = 0; i < SW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [SW-1:0] row4(input int b0, input int b1, input int b2, input int b3);
        return {224'h0, 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    function automatic logic [127:0] gemm_instr(input int dst, input int sa, input int sw,
                                                input int m, input int n, input int k);
        return {8'h01, 8'h01, 16'(dst), 16'(sa), 16'(sw), 16'(m), 16'(n), 16'(k), 16'h0};
    endfunction

    task automatic noc_write(input logic is_instr, input logic [19:0] addr, input logic [SW-1:0] data);
        int w;
        w = 0;
        while (!noc_rx_ready && w < 100) begin
            tick();
            w++;
        end
        if (!noc_rx_ready) check("noc_ready_timeout", noc_rx_ready, 1);
        noc_rx_valid    = 1'b1;
        noc_rx_is_instr = is_instr;
        noc_rx_addr     = addr;
        noc_rx_data     = data;
        tick();
        noc_rx_valid = 1'b0;
    endtask

    task automatic wr_data(input int addr, input logic [SW-1:0] data);
        noc_write(1'b0, 20'(addr), data);
        mdl[addr] = data;
    endtask

    task automatic wr_instr(input logic [7:0] pc, input logic [127:0] ins);
        noc_write(1'b1, {12'h0, pc}, {128'h0, ins});
    endtask

    // C[i][j] = sum_k A[i][k] * B[k][j] on the flat SRAM image, 32-bit wrapping
    task automatic mdl_gemm(input int dst, input int sa, input int sw, input int m, input int n, input int k);
        for (int i = 0; i < m; i++) begin
            logic [SW-1:0] word;
            word = '0;
            for (int j = 0; j < n; j++) begin
                int acc;
                acc = 0;
                for (int kk = 0; kk < k; kk++) begin
                    byte a, b;
                    a = mdl[sa + i][8*kk +: 8];
                    b = mdl[sw + j][8*kk +: 8];
                    acc += int'(a) * int'(b);
                end
                word[32*j +: 32] = acc;
            end
            mdl[dst + i] = word;
        end
    endtask

    task automatic run_prog(input logic [7:0] pc, input int hold, input int grant_delay,
                            output int cyc, output int syncs);
        int sreq, bad_rdy, drop;
        sreq = 0; bad_rdy = 0; drop = 0; syncs = 0;
        tpc_start_pc = {12'h0, pc};
        tpc_start    = 1'b1;
        tick();
        check("busy_on_start", tpc_busy, 1);
        check("done_clr_on_start", tpc_done, 0);
        check("err_clr_on_start", tpc_error, 0);
        for (int h = 1; h < hold; h++) tick();
        tpc_start = 1'b0;
        cyc = hold;
        while (!tpc_done && cyc < 300) begin
            if (noc_rx_ready) bad_rdy++;
            if (sync_request) begin
                if (sreq == grant_delay) begin
                    sync_grant = 1'b1;
                    tick();
                    cyc++;
                    sync_grant = 1'b0;
                    check("sync_release", sync_request, 0);
                    syncs++;
                    sreq = 0;
                end else begin
                    sreq++;
                    tick();
                    cyc++;
                end
            end else begin
                if (sreq != 0) drop++;
                sreq = 0;
                tick();
                cyc++;
            end
        end
        check("run_timeout", tpc_done, 1);
        check("busy_at_done", tpc_busy, 0);
        check("rx_ready_while_busy", bad_rdy, 0);
        check("sync_held", drop, 0);
        check("rx_ready_idle", noc_rx_ready, 1);
        $display("run pc=%0d cycles=%0d syncs=%0d error=%b", pc, cyc, syncs, tpc_error);
    endtask

    task automatic do_gemm(input string tag, input int sw, input int sa, input int dst,
                           input int m, input int n, input int k, input logic [7:0] pc,
                           input int hold, output int cyc);
        int syncs;
        for (int i = 0; i <= m; i++) wr_data(dst + i, rnd_word());
        wr_instr(pc, gemm_instr(dst, sa, sw, m, n, k));
        wr_instr(pc + 8'd1, HALT_I);
        run_prog(pc, hold, 0, cyc, syncs);
        check({tag, "_error"}, tpc_error, 0);
        mdl_gemm(dst, sa, sw, m, n, k);
        for (int i = 0; i <= m; i++) check(tag, peek(dst + i), mdl[dst + i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, syncs, gd, sw, sa, dst, m, n, k, w;
        logic [127:0] bad [4];

        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", tpc_busy, 0);
        check("rst_done", tpc_done, 0);
        check("rst_error", tpc_error, 0);
        check("rst_rx_ready", noc_rx_ready, 1);
        check("rst_sync_req", sync_request, 0);
        check("rst_tx_valid", noc_tx_valid, 0);
        check("rst_axi_valid", {axi_awvalid, axi_wvalid, axi_arvalid}, 0);

        // Reference 4x4x4 GEMM
        wr_data(0, row4(1, 0, 2, 1));
        wr_data(1, row4(0, 1, 1, 2));
        wr_data(2, row4(2, 1, 0, 1));
        wr_data(3, row4(1, 2, 1, 0));
        wr_data(16, row4(1, 2, 3, 4));
        wr_data(17, row4(5, 6, 7, 8));
        wr_data(18, row4(2, 3, 1, 4));
        wr_data(19, row4(1, 1, 2, 2));
        do_gemm("ref4x4", 0, 16, 32, 4, 4, 4, 8'd0, 1, cyc);
        check("ref_row0", peek(32), {128'h0, 32'd8, 32'd8, 32'd13, 32'd11});
        check("ref_row1", peek(33), {128'h0, 32'd24, 32'd24, 32'd29, 32'd27});
        check("ref_row2", peek(34), {128'h0, 32'd9, 32'd11, 32'd12, 32'd8});
        check("ref_row3", peek(35), {128'h0, 32'd5, 32'd5, 32'd7, 32'd7});
        check("ref_latency_le40", (cyc <= 40), 1);

        // Signed extremes
        wr_data(100, row4(127, -1, -128, 3));
        wr_data(104, row4(-1, 127, -128, 2));
        do_gemm("signed", 100, 104, 108, 1, 1, 4, 8'd10, 1, cyc);

        // K=2, N=3 with full random rows
        for (int i = 0; i < 3; i++) wr_data(120 + i, rnd_word());
        for (int i = 0; i < 2; i++) wr_data(130 + i, rnd_word());
        do_gemm("k2n3", 120, 130, 140, 2, 3, 2, 8'd20, 1, cyc);
        check("k2n3_lane3", peek(140) >> 96, 0);

        // Random shapes and bases
        for (int t = 1; t <= 6; t++) begin
            sw  = 150 + 64 * t + int'($urandom_range(0, 7));
            sa  = sw + 8;
            dst = sa + 8;
            m   = int'($urandom_range(1, 4));
            n   = int'($urandom_range(0, 4));
            k   = int'($urandom_range(0, 4));
            for (int i = 0; i < 4; i++) wr_data(sw + i, rnd_word());
            for (int i = 0; i < 4; i++) wr_data(sa + i, rnd_word());
            do_gemm("rand_gemm", sw, sa, dst, m, n, k, 8'($urandom_range(0, 255)), 1, cyc);
        end

        // Illegal instructions: error, done, and no SRAM write to dst
        bad[0] = {8'h7E, 8'h01, 16'd32, 16'd16, 16'd0, 16'd4, 16'd4, 16'd4, 16'h0};
        bad[1] = {8'h01, 8'h02, 16'd32, 16'd16, 16'd0, 16'd4, 16'd4, 16'd4, 16'h0};
        bad[2] = gemm_instr(32, 16, 0, 4, 4, 5);
        bad[3] = gemm_instr(32, 16, 0, 4, 5, 4);
        for (int b = 0; b < 4; b++) begin
            wr_instr(8'd40, bad[b]);
            run_prog(8'd40, 1, 0, cyc, syncs);
            check("bad_error", tpc_error, 1);
            check("bad_done", tpc_done, 1);
            for (int i = 0; i < 4; i++) check("bad_no_write", peek(32 + i), mdl[32 + i]);
        end

        // SYNC barriers around a GEMM
        for (int i = 0; i < 4; i++) wr_data(700 + i, rnd_word());
        for (int i = 0; i < 3; i++) wr_data(710 + i, rnd_word());
        for (int i = 0; i < 4; i++) wr_data(720 + i, rnd_word());
        wr_instr(8'd60, SYNC_I);
        wr_instr(8'd61, gemm_instr(720, 710, 700, 3, 4, 3));
        wr_instr(8'd62, SYNC_I);
        wr_instr(8'd63, HALT_I);
        gd = int'($urandom_range(0, 5));
        run_prog(8'd60, 1, gd, cyc, syncs);
        check("sync_count", syncs, 2);
        check("sync_error", tpc_error, 0);
        mdl_gemm(720, 710, 700, 3, 4, 3);
        for (int i = 0; i < 4; i++) check("sync_gemm", peek(720 + i), mdl[720 + i]);

        // Reset while waiting on a barrier
        wr_instr(8'd80, SYNC_I);
        wr_instr(8'd81, HALT_I);
        tpc_start_pc = 20'd80;
        tpc_start    = 1'b1;
        tick();
        tpc_start = 1'b0;
        w = 0;
        while (!sync_request && w < 20) begin
            tick();
            w++;
        end
        check("rstmid_sync_req", sync_request, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_busy", tpc_busy, 0);
        check("rstmid_sync_req_clr", sync_request, 0);
        check("rstmid_rx_ready", noc_rx_ready, 1);
        check("rstmid_done", tpc_done, 0);
        check("rstmid_sram_kept", peek(33), mdl[33]);
        $display("reset mid-program at pc=80 after %0d wait cycles", w);

        // Rerun the reference program from retained instruction memory
        for (int i = 0; i < 5; i++) wr_data(32 + i, rnd_word());
        run_prog(8'd0, 1, 0, cyc, syncs);
        mdl_gemm(32, 16, 0, 4, 4, 4);
        for (int i = 0; i < 5; i++) check("rerun_gemm", peek(32 + i), mdl[32 + i]);

        // PC wrap 254 -> 255 -> 0 with start held across several cycles
        wr_instr(8'd254, NOP_I);
        wr_instr(8'd255, gemm_instr(500, 16, 0, 4, 4, 4));
        wr_instr(8'd0, HALT_I);
        for (int i = 0; i < 5; i++) wr_data(500 + i, rnd_word());
        run_prog(8'd254, 3, 0, cyc, syncs);
        check("wrap_error", tpc_error, 0);
        mdl_gemm(500, 16, 0, 4, 4, 4);
        for (int i = 0; i < 5; i++) check("wrap_gemm", peek(500 + i), mdl[500 + i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
